axi_hp_issue_ctrl: RTL and testbench

Issue controller for one Zynq PS7 AXI HP port. It arbitrates between one write requester and one read requester and issues AW/AR bursts only when the HP port FIFOs can absorb the whole burst. It uses the HP FIFO fill levels (WACOUNT, WCOUNT, RACOUNT) plus internally tracked reservations. It also drives the RDISSUECAP1EN/WRISSUECAP1EN configuration bits, changing them only while the port is idle.

---
 rtl/axi_hp_issue_ctrl.sv | 171 +++++++++++++++++
 tb/tb_axi_hp_issue_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_hp_issue_ctrl.sv
// Issue controller for one Zynq PS7 AXI HP port: arbitrates one write and one read
// requester and issues AW/AR bursts only when the HP FIFOs can absorb the whole burst.
module axi_hp_issue_ctrl #(
    parameter int unsigned WDATA_DEPTH = 128,
    parameter int unsigned WADDR_DEPTH = 64,
    parameter int unsigned RDATA_DEPTH = 128,
    parameter int unsigned RADDR_DEPTH = 8
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       wr_req,
    input  logic [3:0] wr_len,
    output logic       wr_ack,
    input  logic       rd_req,
    input  logic [3:0] rd_len,
    output logic       rd_ack,
    output logic       AWVALID,
    input  logic       AWREADY,
    output logic [3:0] AWLEN,
    output logic       ARVALID,
    input  logic       ARREADY,
    output logic [3:0] ARLEN,
    input  logic       w_beat,
    input  logic       r_beat,
    input  logic [5:0] WACOUNT,
    input  logic [7:0] WCOUNT,
    input  logic [2:0] RACOUNT,
    input  logic       cfg_rd_cap1,
    input  logic       cfg_wr_cap1,
    output logic       RDISSUECAP1EN,
    output logic       WRISSUECAP1EN,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_AR
    } state_t;

    localparam logic [6:0] WADDR_LIM = 7'(WADDR_DEPTH - 1);
    localparam logic [3:0] RADDR_LIM = 4'(RADDR_DEPTH - 1);
    localparam logic [9:0] WDATA_LIM = 10'(WDATA_DEPTH);
    localparam logic [9:0] RDATA_LIM = 10'(RDATA_DEPTH);

    state_t     state_q, state_d;
    logic [3:0] awlen_q, awlen_d;
    logic [3:0] arlen_q, arlen_d;
    logic       wr_ack_q, wr_ack_d;
    logic       rd_ack_q, rd_ack_d;
    logic       last_wr_q, last_wr_d;
    logic [7:0] w_pend_q, w_pend_d;
    logic [7:0] r_resv_q, r_resv_d;
    logic       err_q, err_d;
    logic       rcap_q, rcap_d;
    logic       wcap_q, wcap_d;

    logic [9:0] w_sum, r_sum;
    logic       w_elig, r_elig, pick_w, pick_r;
    logic       aw_hs, ar_hs;
    logic [7:0] w_inc, r_inc;

    // Sums are kept at 10 bits so no combination of fill levels can wrap.
    always_comb begin
        w_sum  = {2'b00, WCOUNT} + {2'b00, w_pend_q} + {6'd0, wr_len} + 10'd1;
        r_sum  = {2'b00, r_resv_q} + {6'd0, rd_len} + 10'd1;
        w_elig = wr_req && ({1'b0, WACOUNT} < WADDR_LIM) && (w_sum <= WDATA_LIM);
        r_elig = rd_req && ({1'b0, RACOUNT} < RADDR_LIM) && (r_sum <= RDATA_LIM);
        pick_w = (state_q == ST_IDLE) && w_elig && (!r_elig || !last_wr_q);
        pick_r = (state_q == ST_IDLE) && r_elig && !pick_w;
        aw_hs  = (state_q == ST_AW) && AWREADY;
        ar_hs  = (state_q == ST_AR) && ARREADY;
        w_inc  = aw_hs ? ({4'd0, awlen_q} + 8'd1) : '0;
        r_inc  = ar_hs ? ({4'd0, arlen_q} + 8'd1) : '0;
    end

    always_comb begin
        state_d   = state_q;
        awlen_d   = awlen_q;
        arlen_d   = arlen_q;
        wr_ack_d  = 1'b0;
        rd_ack_d  = 1'b0;
        last_wr_d = last_wr_q;
        err_d     = err_q;
        rcap_d    = rcap_q;
        wcap_d    = wcap_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_w) begin
                    state_d = ST_AW;
                    awlen_d = wr_len;
                end else if (pick_r) begin
                    state_d = ST_AR;
                    arlen_d = rd_len;
                end
            end
            ST_AW: begin
                if (AWREADY) begin
                    state_d   = ST_IDLE;
                    wr_ack_d  = 1'b1;
                    last_wr_d = 1'b1;
                end
            end
            ST_AR: begin
                if (ARREADY) begin
                    state_d   = ST_IDLE;
                    rd_ack_d  = 1'b1;
                    last_wr_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An underflowing beat is dropped; any same-cycle increment still lands.
        w_pend_d = w_pend_q + w_inc;
        if (w_beat) begin
            if (w_pend_q == '0) err_d = 1'b1;
            else                w_pend_d = w_pend_q + w_inc - 8'd1;
        end
        r_resv_d = r_resv_q + r_inc;
        if (r_beat) begin
            if (r_resv_q == '0) err_d = 1'b1;
            else                r_resv_d = r_resv_q + r_inc - 8'd1;
        end

        if ((state_q == ST_IDLE) && (w_pend_q == '0) && (r_resv_q == '0) && !pick_w && !pick_r) begin
            rcap_d = cfg_rd_cap1;
            wcap_d = cfg_wr_cap1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            awlen_q   <= '0;
            arlen_q   <= '0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            last_wr_q <= 1'b0;
            w_pend_q  <= '0;
            r_resv_q  <= '0;
            err_q     <= 1'b0;
            rcap_q    <= 1'b0;
            wcap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            awlen_q   <= awlen_d;
            arlen_q   <= arlen_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            last_wr_q <= last_wr_d;
            w_pend_q  <= w_pend_d;
            r_resv_q  <= r_resv_d;
            err_q     <= err_d;
            rcap_q    <= rcap_d;
            wcap_q    <= wcap_d;
        end
    end

    assign AWVALID       = (state_q == ST_AW);
    assign ARVALID       = (state_q == ST_AR);
    assign AWLEN         = awlen_q;
    assign ARLEN         = arlen_q;
    assign wr_ack        = wr_ack_q;
    assign rd_ack        = rd_ack_q;
    assign err           = err_q;
    assign RDISSUECAP1EN = rcap_q;
    assign WRISSUECAP1EN = wcap_q;

endmodule

// File: tb/tb_axi_hp_issue_ctrl.sv
// Directed self-checking bench for axi_hp_issue_ctrl.
module tb_axi_hp_issue_ctrl;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic       wr_req, rd_req, wr_ack, rd_ack;
    logic [3:0] wr_len, rd_len, AWLEN, ARLEN;
    logic       AWVALID, AWREADY, ARVALID, ARREADY;
    logic       w_beat, r_beat;
    logic [5:0] WACOUNT;
    logic [7:0] WCOUNT;
    logic [2:0] RACOUNT;
    logic       cfg_rd_cap1, cfg_wr_cap1, RDISSUECAP1EN, WRISSUECAP1EN, err;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 ACLK = ~ACLK;

    axi_hp_issue_ctrl #(
        .WDATA_DEPTH(128),
        .WADDR_DEPTH(64),
        .RDATA_DEPTH(128),
        .RADDR_DEPTH(8)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .wr_req(wr_req), .wr_len(wr_len), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_len(rd_len), .rd_ack(rd_ack),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN),
        .w_beat(w_beat), .r_beat(r_beat),
        .WACOUNT(WACOUNT), .WCOUNT(WCOUNT), .RACOUNT(RACOUNT),
        .cfg_rd_cap1(cfg_rd_cap1), .cfg_wr_cap1(cfg_wr_cap1),
        .RDISSUECAP1EN(RDISSUECAP1EN), .WRISSUECAP1EN(WRISSUECAP1EN),
        .err(err)
    );

    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic pulse_w(input int n);
        w_beat = 1'b1;
        repeat (n) tick();
        w_beat = 1'b0;
    endtask

    task automatic pulse_r(input int n);
        r_beat = 1'b1;
        repeat (n) tick();
        r_beat = 1'b0;
    endtask

    initial begin
        int unsigned cnt;
        int unsigned seen;
        int unsigned n;
        int unsigned got [4];

        ARESET = 1'b1;
        wr_req = 1'b0; rd_req = 1'b0; wr_len = '0; rd_len = '0;
        AWREADY = 1'b0; ARREADY = 1'b0; w_beat = 1'b0; r_beat = 1'b0;
        WACOUNT = '0; WCOUNT = '0; RACOUNT = '0;
        cfg_rd_cap1 = 1'b0; cfg_wr_cap1 = 1'b0;
        repeat (3) tick();
        ARESET = 1'b0;

        chk("rst_awvalid", AWVALID, 0);
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_awlen", AWLEN, 0);
        chk("rst_arlen", ARLEN, 0);
        chk("rst_acks", {wr_ack, rd_ack}, 0);
        chk("rst_err", err, 0);
        chk("rst_caps", {RDISSUECAP1EN, WRISSUECAP1EN}, 0);

        // Single 16-beat write burst
        wr_req = 1'b1; wr_len = 4'd15; AWREADY = 1'b1;
        tick();
        chk("w1_awvalid", AWVALID, 1);
        chk("w1_awlen", AWLEN, 15);
        tick();
        chk("w1_ack", wr_ack, 1);
        chk("w1_awvalid_lo", AWVALID, 0);
        chk("w1_pend", dut.w_pend_q, 16);
        wr_req = 1'b0;
        pulse_w(16);
        chk("w1_drain", dut.w_pend_q, 0);
        chk("w1_err", err, 0);

        // WCOUNT boundary: 112+16 fits, 113+16 does not
        WCOUNT = 8'd112; wr_req = 1'b1;
        tick();
        chk("wc112_issue", AWVALID, 1);
        tick();
        chk("wc112_ack", wr_ack, 1);
        wr_req = 1'b0;
        pulse_w(16);
        WCOUNT = 8'd113; wr_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (AWVALID) seen = 1;
        end
        chk("wc113_stall", seen, 0);
        WCOUNT = 8'd112;
        tick();
        chk("wc_release", AWVALID, 1);
        tick();
        chk("wc_release_ack", wr_ack, 1);
        wr_req = 1'b0; WCOUNT = '0;
        pulse_w(16);

        // Read reservations fill to 128 after exactly 8 bursts
        rd_req = 1'b1; rd_len = 4'd15; ARREADY = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rd_ack) cnt++;
        end
        chk("rd_bursts", cnt, 8);
        chk("rd_resv_full", dut.r_resv_q, 128);
        chk("rd_stalled", ARVALID, 0);
        pulse_r(1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ARVALID) seen = 1;
        end
        chk("rd_one_beat_stall", seen, 0);
        chk("rd_resv_127", dut.r_resv_q, 127);
        pulse_r(15);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd_ack) begin
                seen = 1;
                rd_req = 1'b0;
                break;
            end
        end
        rd_req = 1'b0;
        chk("rd_release", seen, 1);
        chk("rd_resv_refill", dut.r_resv_q, 128);
        pulse_r(128);
        chk("rd_drain", dut.r_resv_q, 0);
        chk("rd_err", err, 0);

        // Round-robin with both requesters eligible
        wr_len = '0; rd_len = '0; wr_req = 1'b1; rd_req = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) got[i] = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            tick();
            if (wr_ack)      begin got[n] = 1; n++; end
            else if (rd_ack) begin got[n] = 2; n++; end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        chk("rr_grant0_w", got[0], 1);
        chk("rr_grant1_r", got[1], 2);
        chk("rr_grant2_w", got[2], 1);
        chk("rr_grant3_r", got[3], 2);
        w_beat = 1'b1; r_beat = 1'b1;
        repeat (2) tick();
        w_beat = 1'b0; r_beat = 1'b0;
        chk("rr_drain", {dut.w_pend_q, dut.r_resv_q}, 0);

        // AWREADY held low: AW parked, no AR interleaves
        AWREADY = 1'b0; wr_len = 4'd7; rd_len = 4'd3; wr_req = 1'b1; rd_req = 1'b1;
        tick();
        chk("stall_awvalid", AWVALID, 1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!AWVALID || AWLEN != 4'd7 || ARVALID) seen = 1;
        end
        chk("stall_hold", seen, 0);
        AWREADY = 1'b1;
        tick();
        chk("stall_ack", wr_ack, 1);
        wr_req = 1'b0;
        tick();
        chk("stall_then_ar", ARVALID, 1);
        chk("stall_arlen", ARLEN, 3);
        tick();
        chk("stall_rd_ack", rd_ack, 1);
        rd_req = 1'b0;
        pulse_w(8);
        pulse_r(4);

        // Cap bit only loads once the port is fully idle
        wr_len = 4'd3; wr_req = 1'b1;
        tick();
        tick();
        chk("cap_wr_ack", wr_ack, 1);
        wr_req = 1'b0;
        chk("cap_pend4", dut.w_pend_q, 4);
        cfg_wr_cap1 = 1'b1;
        pulse_w(3);
        tick();
        chk("cap_held_3", WRISSUECAP1EN, 0);
        pulse_w(1);
        chk("cap_held_4", WRISSUECAP1EN, 0);
        tick();
        chk("cap_loaded", WRISSUECAP1EN, 1);

        // Reset mid-burst, then underflow sets sticky err
        wr_len = 4'd15; wr_req = 1'b1; AWREADY = 1'b1;
        tick();
        tick();
        AWREADY = 1'b0;
        tick();
        chk("rstmid_awvalid", AWVALID, 1);
        ARESET = 1'b1; wr_req = 1'b0;
        tick();
        chk("rstmid_awvalid_lo", AWVALID, 0);
        chk("rstmid_pend", dut.w_pend_q, 0);
        chk("rstmid_cap", WRISSUECAP1EN, 0);
        ARESET = 1'b0;
        pulse_w(1);
        chk("uflow_err", err, 1);
        chk("uflow_pend", dut.w_pend_q, 0);
        repeat (3) tick();
        chk("uflow_sticky", err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
